pipe_skid_stage: RTL

PIPE_SKID_STAGE -- requirements
Module: pipe_skid_stage

---
 rtl/pipe_pkg.sv | 15 +
 rtl/pipe_dffe.sv | 26 ++
 rtl/pipe_skid_stage.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// Shared definitions for the pipe skid stage: state encoding and the
// default payload / counter widths used by the top level.
package pipe_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int CNT_W_DEF  = 8;

    // Encoding doubles as the number of words held (0, 1 or 2).
    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_FULL  = 2'b01,
        ST_SKID  = 2'b10
    } state_t;

endpackage

// File: rtl/pipe_dffe.sv
// Parametrised-width enable flop with synchronous active-high reset.
// Ports:
//   clk - clock (rising edge)
//   rst - synchronous reset, clears q to zero, wins over en
//   en  - load enable
//   d   - next value
//   q   - registered value
module pipe_dffe #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/pipe_skid_stage.sv
// Valid/ready pipeline stage with optional skid buffer and a saturating
// back-pressure counter.
//   SKID=1 : two-entry stage, in_ready comes straight from a flop so the
//            upstream ready path is cut from out_ready.
//   SKID=0 : one-entry stage, in_ready = !out_valid || out_ready.
// Ports:
//   clk, rst            - clock and synchronous active-high reset
//   in_valid/in_data    - upstream offer
//   in_ready            - stage accepts a word this cycle
//   out_valid/out_data  - oldest held word
//   out_ready           - downstream accepts out_data
//   flush               - drop held words and the word offered this cycle
//   stall_cnt           - saturating count of back-pressured cycles
module pipe_skid_stage
    import pipe_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int SKID   = 1,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
    input  logic              flush,
    output logic [CNT_W-1:0]  stall_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (v == CNT_MAX) begin
            return v;
        end
        return v + CNT_W'(1);
    endfunction

    state_t            state_q;
    state_t            state_d;
    logic              in_ready_q;
    logic              in_xfer;
    logic              out_xfer;
    logic              out_en;
    logic [DATA_W-1:0] out_d;
    logic              skid_en;
    logic [DATA_W-1:0] skid_q;
    logic              stall_en;
    logic [CNT_W-1:0]  stall_d;

    assign out_valid = (state_q != ST_EMPTY);
    assign in_ready  = (SKID != 0) ? in_ready_q : (!out_valid || out_ready);
    assign in_xfer   = in_valid && in_ready && !flush;
    assign out_xfer  = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // in_ready is held low for the cycle right after reset, then tracks
    // whether the next state leaves room for another word.
    always_ff @(posedge clk) begin
        if (rst) begin
            in_ready_q <= 1'b0;
        end else begin
            in_ready_q <= (state_d != ST_SKID);
        end
    end

    always_comb begin
        state_d = state_q;
        out_en  = 1'b0;
        out_d   = in_data;
        skid_en = 1'b0;
        if (flush) begin
            // Data registers keep their contents; only occupancy is cleared.
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (in_xfer) begin
                        state_d = ST_FULL;
                        out_en  = 1'b1;
                    end
                end
                ST_FULL: begin
                    if (in_xfer && out_xfer) begin
                        out_en = 1'b1;
                    end else if (in_xfer) begin
                        // Only reachable with SKID=1: SKID=0 never accepts
                        // into a full stage without draining it.
                        state_d = ST_SKID;
                        skid_en = 1'b1;
                    end else if (out_xfer) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_SKID: begin
                    if (out_xfer) begin
                        state_d = ST_FULL;
                        out_en  = 1'b1;
                        out_d   = skid_q;
                    end
                end
                default: begin
                    state_d = ST_EMPTY;
                end
            endcase
        end
    end

    assign stall_en = out_valid && !out_ready;
    assign stall_d  = sat_inc(stall_cnt);

    pipe_dffe #(.W(DATA_W)) u_out_reg (
        .clk (clk),
        .rst (rst),
        .en  (out_en),
        .d   (out_d),
        .q   (out_data)
    );

    pipe_dffe #(.W(DATA_W)) u_skid_reg (
        .clk (clk),
        .rst (rst),
        .en  (skid_en),
        .d   (in_data),
        .q   (skid_q)
    );

    pipe_dffe #(.W(CNT_W)) u_stall_reg (
        .clk (clk),
        .rst (rst),
        .en  (stall_en),
        .d   (stall_d),
        .q   (stall_cnt)
    );

endmodule
